// File: rtl/sha2_msg_schedule_if.sv
// sha2_msg_schedule_if
// Purpose : bundles the block-input and word-output handshakes of the SHA-2
//           message schedule generator.
// Signals : flush_in      - synchronous abort back to IDLE
//           blk_valid_in  - 16-word block offered on blk_in
//           blk_ready_out - schedule can accept a block
//           blk_in        - message block, word 0 in the MSBs
//           w_valid_out   - w_out carries schedule word W_t
//           w_ready_in    - consumer takes w_out
//           w_out         - schedule word W_t
//           round_out     - index t of w_out
//           w_last_out    - w_out is the final word of the block
//           busy_out      - a block is in flight
// Modports: slave  - the schedule generator
//           master - the producer/consumer side driving it
interface sha2_msg_schedule_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 7
);
  logic                   flush_in;
  logic                   blk_valid_in;
  logic                   blk_ready_out;
  logic [16*WORD_W-1:0]   blk_in;
  logic                   w_valid_out;
  logic                   w_ready_in;
  logic [WORD_W-1:0]      w_out;
  logic [CNT_W-1:0]       round_out;
  logic                   w_last_out;
  logic                   busy_out;

  modport slave (
    input  flush_in, blk_valid_in, blk_in, w_ready_in,
    output blk_ready_out, w_valid_out, w_out, round_out, w_last_out, busy_out
  );

  modport master (
    output flush_in, blk_valid_in, blk_in, w_ready_in,
    input  blk_ready_out, w_valid_out, w_out, round_out, w_last_out, busy_out
  );
endinterface

// File: rtl/sha2_msg_schedule.sv
// sha2_msg_schedule
// Purpose : generates W_0..W_{ROUNDS-1} from one 16-word message block for
//           SHA-224/256 (WORD_W=32, ROUNDS=64) or SHA-384/512 (WORD_W=64,
//           ROUNDS=80). A 16-word sliding window shifts once per accepted
//           output word, so win[0] is always the word being presented.
// Ports   : CLK - rising-edge clock
//           RST - asynchronous active-low reset
//           bus - sha2_msg_schedule_if.slave (block in, word out, flush)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | window cleared, waiting for a block (blk_ready_out=1)
// RUN   | presenting W_t from win[0], shifting on every transfer
module sha2_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  sha2_msg_schedule_if.slave   bus
);

  // Small/large sigma rotate and shift amounts for the two word widths.
  localparam int S0_A = (WORD_W == 64) ? 1  : 7;
  localparam int S0_B = (WORD_W == 64) ? 8  : 18;
  localparam int S0_C = (WORD_W == 64) ? 7  : 3;
  localparam int S1_A = (WORD_W == 64) ? 19 : 17;
  localparam int S1_B = (WORD_W == 64) ? 61 : 19;
  localparam int S1_C = (WORD_W == 64) ? 6  : 10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WORD_W-1:0]   win [16];
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   sig0_w;
  logic [WORD_W-1:0]   sig1_w;
  logic [WORD_W-1:0]   nxt;
  logic                xfer;
  logic                last;
  logic                load;
  logic                shift;
  logic                clear;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Next schedule word from the current window: W_{t+16} from W_t..W_{t+15}.
  always_comb begin
    sig0_w = rotr(win[1], S0_A) ^ rotr(win[1], S0_B) ^ (win[1] >> S0_C);
    sig1_w = rotr(win[14], S1_A) ^ rotr(win[14], S1_B) ^ (win[14] >> S1_C);
    nxt    = sig1_w + win[9] + sig0_w + win[0];
  end

  assign last = (state == RUN) && (cnt == CNT_W'(ROUNDS - 1));
  assign xfer = (state == RUN) && bus.w_ready_in;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // flush_in wins over load and transfer in every state.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
    if (bus.flush_in) begin
      state_nxt = IDLE;
      clear     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.blk_valid_in) begin
            state_nxt = RUN;
            load      = 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last) begin
              state_nxt = IDLE;
              clear     = 1'b1;
            end else begin
              shift = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) win[i] <= bus.blk_in[(16-i)*WORD_W-1 -: WORD_W];
    end else if (shift) begin
      cnt <= cnt + CNT_W'(1);
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= nxt;
    end
  end

  // Ready is withheld during flush so a producer never sees a handshake
  // that the schedule then drops.
  assign bus.blk_ready_out = (state == IDLE) && !bus.flush_in;
  assign bus.w_valid_out   = (state == RUN);
  assign bus.w_out         = win[0];
  assign bus.round_out     = cnt;
  assign bus.w_last_out    = last;
  assign bus.busy_out      = (state != IDLE);

endmodule

// File: doc/sha2_msg_schedule.md
Name: sha2_msg_schedule

Overview:
Parametrised SHA-2 message schedule generator. It produces W_0..W_{ROUNDS-1} from one 16-word block, for SHA-224/256 (32-bit words, 64 rounds) or SHA-384/512 (64-bit words, 80 rounds). It sits between the block padder and the compression round engine. Valid/ready handshakes on both sides let the round engine stall the schedule.

Parameters:
WORD_W, 32, word width; legal values 32 (SHA-256 family) or 64 (SHA-512 family); selects the sigma functions.
ROUNDS, 64, number of schedule words emitted; 64 when WORD_W=32, 80 when WORD_W=64.
CNT_W, 7, round counter width; must satisfy 2^CNT_W > ROUNDS.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-low.
flush_in  in  1  synchronous abort; returns the block to IDLE.
blk_valid_in  in  1  block offered.
blk_ready_out  out  1  block can be accepted.
blk_in  in  16*WORD_W  message block; word i at bits [(16-i)*WORD_W-1 -: WORD_W], so word 0 is at the MSBs.
w_valid_out  out  1  w_out holds a valid schedule word.
w_ready_in  in  1  consumer accepts w_out.
w_out  out  WORD_W  schedule word W_t.
round_out  out  CNT_W  index t of w_out.
w_last_out  out  1  high with W_{ROUNDS-1}.
busy_out  out  1  state != IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; window words win[0..15]=0; round counter=0.
  - Outputs: w_valid_out=0, w_last_out=0, busy_out=0, w_out=0, round_out=0, blk_ready_out=1.
- Storage: a 16-word window register win[0..15]. w_out is driven by win[0] directly (registered source, no combinational path from inputs).
- Sigma functions:
  - WORD_W=32: s0(x)=ROTR7^ROTR18^SHR3; s1(x)=ROTR17^ROTR19^SHR10.
  - WORD_W=64: s0(x)=ROTR1^ROTR8^SHR7; s1(x)=ROTR19^ROTR61^SHR6.
- New word: nxt = s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^WORD_W (carries discarded).
- States:
  - IDLE:
    - blk_ready_out=1, w_valid_out=0.
    - On blk_valid_in & blk_ready_out: win[i] <= word i of blk_in, round counter <= 0, go to RUN.
    - Latency: block accepted at edge N gives w_valid_out=1 with W_0 in the cycle after edge N.
  - RUN:
    - blk_ready_out=0, w_valid_out=1, round_out=round counter.
    - Transfer = w_valid_out & w_ready_in.
    - On a transfer: shift win[i] <= win[i+1] for i=0..14, win[15] <= nxt, round counter += 1. Because the shift happens on every transfer from t=0, the window always holds W_t..W_{t+15}.
    - Without a transfer (w_ready_in=0): window, counter and w_out hold unchanged for any stall length.
    - w_last_out = (round counter == ROUNDS-1).
    - A transfer while w_last_out=1: go to IDLE, round counter <= 0, window cleared to 0.
- Back-to-back blocks: blk_ready_out rises in the cycle after the last transfer. Throughput is therefore ROUNDS+1 cycles per block with w_ready_in held high. No overlap of blocks.
- flush_in:
  - Takes priority over every other event in any state.
  - Next state is IDLE; window and counter are cleared.
  - A block offered in the same cycle as flush_in is not accepted.
- blk_valid_in while in RUN is ignored; blk_ready_out=0 tells the producer to hold it.
- Reset asserted mid-block: immediate return to the reset values; no partial word is emitted after release.
- round_out and w_out are stable whenever w_valid_out=1 and w_ready_in=0.

Test Plan:
1. WORD_W=32, block "abc" (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready_in=1 -> 64 words with round_out 0..63. W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405. w_last_out only at t=63. blk_ready_out=1 in the cycle after.
2. WORD_W=64, ROUNDS=80, block W0=0x6162638000000000, W15=0x18 -> W16=0x6162638000000000, W17=0x00030000000000C0. 80 words emitted; w_last_out at t=79.
3. Stall: case 1 with w_ready_in low for 5 cycles at t=17 -> w_out holds 0x000F0000 with round_out=17 throughout the stall. The full sequence is identical to case 1.
4. Back-to-back blocks with blk_valid_in held high -> second block accepted exactly 1 cycle after the t=63 transfer. Its W0 is emitted with round_out=0 and no stale words.
5. flush_in pulsed at t=30, with blk_valid_in also high -> IDLE next cycle, w_valid_out=0, block not accepted. A block offered afterwards produces the correct schedule from t=0.
6. RST pulsed low at t=40 -> all outputs at their reset values immediately; after release blk_ready_out=1, and a new "abc" block reproduces case 1.
